sort_stream_ctrl: RTL and testbench

Packet-level controller that sits upstream and downstream of the in-place RAM sorter. It accepts one packet of words on a ready/valid sink stream and writes it into the shared dual-port RAM. It then starts the sorter, waits for its done pulse, and streams the sorted words back out on a ready/valid source stream with start/end-of-packet markers. It owns the RAM ports and hands them to the sorter only while a sort is in progress.

---
 rtl/sort_stream_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sort_stream_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_ctrl.sv
// Packet controller around an in-place RAM sorter: load a packet, sort it, stream it back out.
// Optional macro SORT_STATS_EN adds sort_cycles_o (cycles from START to the accepted done).
`timescale 1ns/1ps
module sort_stream_ctrl #(
    parameter int DWIDTH  = 10,
    parameter int ADDR_SZ = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [DWIDTH-1:0]  snk_data_i,
    input  logic               snk_valid_i,
    input  logic               snk_sop_i,
    input  logic               snk_eop_i,
    output logic               snk_ready_o,
    output logic [DWIDTH-1:0]  src_data_o,
    output logic               src_valid_o,
    output logic               src_sop_o,
    output logic               src_eop_o,
    input  logic               src_ready_i,
    output logic [ADDR_SZ-1:0] ram_address_a_o,
    output logic [ADDR_SZ-1:0] ram_address_b_o,
    output logic [DWIDTH-1:0]  ram_data_a_o,
    output logic [DWIDTH-1:0]  ram_data_b_o,
    output logic               ram_wren_a_o,
    output logic               ram_wren_b_o,
    input  logic [DWIDTH-1:0]  ram_q_a_i,
    input  logic [DWIDTH-1:0]  ram_q_b_i,
    input  logic [ADDR_SZ-1:0] srt_address_a_i,
    input  logic [ADDR_SZ-1:0] srt_address_b_i,
    input  logic [DWIDTH-1:0]  srt_data_a_i,
    input  logic [DWIDTH-1:0]  srt_data_b_i,
    input  logic               srt_wren_a_i,
    input  logic               srt_wren_b_i,
    output logic               srt_sorting_o,
    output logic [ADDR_SZ:0]   srt_max_counter_o,
    input  logic               srt_done_i,
    output logic               overflow_o,
`ifdef SORT_STATS_EN
    output logic [31:0]        sort_cycles_o,
`endif
    output logic [2:0]         state_o
);
    // Both streams use valid/ready: a beat transfers on a rising clock edge where valid and
    // ready are both high; the source holds data and markers stable while valid is high and ready is low.
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, WAIT = 3'd3, UNLOAD = 3'd4} state_t;

    localparam logic [ADDR_SZ:0] CAP = {1'b1, {ADDR_SZ{1'b0}}};
    localparam logic [ADDR_SZ:0] ONE = (ADDR_SZ+1)'(1);
    localparam logic [ADDR_SZ:0] TWO = (ADDR_SZ+1)'(2);

    state_t            state, state_nxt;
    logic              alive;
    logic [ADDR_SZ:0]  count, count_nxt, rd_addr;
    logic [1:0]        wait_cnt, occ, eff_occ;
    logic              inflight, in_sop, in_eop, rd_ptr, wr_ptr;
    logic [DWIDTH-1:0] fifo_data [2];
    logic              fifo_sop [2];
    logic              fifo_eop [2];
    logic              accept, sop_beat, load_full, load_wr, done_take, pop, issue, sorter_owns;
    logic              unused_ok;

    assign unused_ok   = ^ram_q_b_i;
    assign accept      = snk_valid_i & snk_ready_o;
    assign sop_beat    = (state == IDLE) & accept & snk_sop_i;
    assign load_full   = (count == CAP);
    assign load_wr     = (state == LOAD) & accept & ~load_full;
    assign count_nxt   = count + {{ADDR_SZ{1'b0}}, load_wr};
    assign done_take   = (state == WAIT) & (wait_cnt == 2'd2) & srt_done_i;
    assign pop         = src_valid_o & src_ready_i;
    // Occupancy after this cycle's pop plus the read already in flight; keeps the 2-entry FIFO from overrunning.
    assign eff_occ     = occ - {1'b0, pop} + {1'b0, inflight};
    assign issue       = (state == UNLOAD) & (rd_addr != count) & (eff_occ < 2'd2);
    assign sorter_owns = (state == START) | ((state == WAIT) & ~done_take);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sop_beat) state_nxt = snk_eop_i ? UNLOAD : LOAD;
            LOAD:    if (accept && snk_eop_i) state_nxt = (count_nxt >= TWO) ? START : UNLOAD;
            START:   state_nxt = WAIT;
            WAIT:    if (done_take) state_nxt = UNLOAD;
            UNLOAD:  if (pop && src_eop_o) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        snk_ready_o       = alive & ((state == IDLE) | (state == LOAD));
        srt_sorting_o     = (state == START);
        srt_max_counter_o = ((state == START) | (state == WAIT)) ? count : '0;
        state_o           = state;
        ram_address_a_o   = '0;
        ram_data_a_o      = '0;
        ram_wren_a_o      = 1'b0;
        ram_address_b_o   = '0;
        ram_data_b_o      = '0;
        ram_wren_b_o      = 1'b0;
        if (sorter_owns) begin
            ram_address_a_o = srt_address_a_i;
            ram_data_a_o    = srt_data_a_i;
            ram_wren_a_o    = srt_wren_a_i;
            ram_address_b_o = srt_address_b_i;
            ram_data_b_o    = srt_data_b_i;
            ram_wren_b_o    = srt_wren_b_i;
        end else begin
            case (state)
                IDLE: begin
                    ram_data_a_o = snk_data_i;
                    ram_wren_a_o = sop_beat;
                end
                LOAD: begin
                    ram_address_a_o = count[ADDR_SZ-1:0];
                    ram_data_a_o    = snk_data_i;
                    ram_wren_a_o    = load_wr;
                end
                UNLOAD:  ram_address_a_o = rd_addr[ADDR_SZ-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alive      <= 1'b0;
            count      <= '0;
            overflow_o <= 1'b0;
            wait_cnt   <= '0;
            rd_addr    <= '0;
            inflight   <= 1'b0;
            in_sop     <= 1'b0;
            in_eop     <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (sop_beat)     count <= ONE;
            else if (load_wr) count <= count_nxt;
            if (sop_beat) overflow_o <= 1'b0;
            else if ((state == LOAD) && accept && load_full) overflow_o <= 1'b1;
            // A done pulse in the first two WAIT cycles may be left over from a previous sort.
            if (state == START) wait_cnt <= '0;
            else if ((state == WAIT) && (wait_cnt != 2'd2)) wait_cnt <= wait_cnt + 2'd1;
            if (state != UNLOAD) rd_addr <= '0;
            else if (issue)      rd_addr <= rd_addr + ONE;
            inflight <= issue;
            in_sop   <= (rd_addr == '0);
            in_eop   <= (rd_addr == count - ONE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ    <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_sop[i]  <= 1'b0;
                fifo_eop[i]  <= 1'b0;
            end
        end else begin
            if (inflight) begin
                fifo_data[wr_ptr] <= ram_q_a_i;
                fifo_sop[wr_ptr]  <= in_sop;
                fifo_eop[wr_ptr]  <= in_eop;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

    assign src_valid_o = (occ != 2'd0);
    assign src_data_o  = src_valid_o ? fifo_data[rd_ptr] : '0;
    assign src_sop_o   = src_valid_o & fifo_sop[rd_ptr];
    assign src_eop_o   = src_valid_o & fifo_eop[rd_ptr];

`ifdef SORT_STATS_EN
    logic [31:0] run_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt       <= '0;
            sort_cycles_o <= '0;
        end else begin
            if (state == START)     run_cnt <= 32'd1;
            else if (state == WAIT) run_cnt <= sat_inc(run_cnt);
            if (done_take) sort_cycles_o <= sat_inc(run_cnt);
            else if ((state_nxt == UNLOAD) && (state != UNLOAD)) sort_cycles_o <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: random packets, RAM and sorter models, queue scoreboard.
`timescale 1ns/1ps
module tb_sort_stream_ctrl;
    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int W     = DW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] snk_data, src_data, ram_data_a, ram_data_b, ram_q_a, ram_q_b, srt_data_a, srt_data_b;
    logic          snk_valid, snk_sop, snk_eop, snk_ready, src_valid, src_sop, src_eop, src_ready;
    logic [AW-1:0] ram_address_a, ram_address_b, srt_address_a, srt_address_b;
    logic          ram_wren_a, ram_wren_b, srt_wren_a, srt_wren_b, srt_sorting, srt_done, overflow;
    logic [AW:0]   srt_max_counter;
    logic [2:0]    state_unused;
`ifdef SORT_STATS_EN
    logic [31:0]   sort_cycles;
`endif

    always #5 clk = ~clk;

    sort_stream_ctrl #(.DWIDTH(DW), .ADDR_SZ(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .snk_data_i(snk_data), .snk_valid_i(snk_valid), .snk_sop_i(snk_sop), .snk_eop_i(snk_eop),
        .snk_ready_o(snk_ready),
        .src_data_o(src_data), .src_valid_o(src_valid), .src_sop_o(src_sop), .src_eop_o(src_eop),
        .src_ready_i(src_ready),
        .ram_address_a_o(ram_address_a), .ram_address_b_o(ram_address_b),
        .ram_data_a_o(ram_data_a), .ram_data_b_o(ram_data_b),
        .ram_wren_a_o(ram_wren_a), .ram_wren_b_o(ram_wren_b),
        .ram_q_a_i(ram_q_a), .ram_q_b_i(ram_q_b),
        .srt_address_a_i(srt_address_a), .srt_address_b_i(srt_address_b),
        .srt_data_a_i(srt_data_a), .srt_data_b_i(srt_data_b),
        .srt_wren_a_i(srt_wren_a), .srt_wren_b_i(srt_wren_b),
        .srt_sorting_o(srt_sorting), .srt_max_counter_o(srt_max_counter),
        .srt_done_i(srt_done), .overflow_o(overflow),
`ifdef SORT_STATS_EN
        .sort_cycles_o(sort_cycles),
`endif
        .state_o(state_unused)
    );

    int checks = 0, errors = 0, cyc = 0;
    logic [W-1:0]  exp_q[$];
    bit            exp_ovf_q[$];
    bit            exp_sorted_q[$];
    logic [DW-1:0] pkt[$];
    logic [DW-1:0] mem [DEPTH];
    int  epoch = 0, starts = 0, last_n = 0, start_cyc = 0, done_cyc = 0, ready_mode = 0, pat_idx = 0;
    bit  busy = 0, stale = 0, long_sort = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Dual-port RAM with 1-cycle registered read.
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
        ram_q_a <= mem[ram_address_a];
        ram_q_b <= mem[ram_address_b];
    end

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       src_ready = 1'b1;
            1:       src_ready = 1'($urandom_range(0, 1));
            default: begin
                src_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                pat_idx++;
            end
        endcase
    end

    // Sorter model: sorts through the srt_* write ports, then pulses done.
    int            s_epoch, s_n, s_d;
    logic [DW-1:0] s_arr [DEPTH];
    logic [DW-1:0] s_tmp;
    initial begin : sorter_model
        srt_address_a = '0; srt_address_b = '0; srt_data_a = '0; srt_data_b = '0;
        srt_wren_a = 1'b0; srt_wren_b = 1'b0; srt_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && srt_sorting) begin
                s_epoch = epoch; s_n = int'(srt_max_counter);
                busy = 1; starts++; last_n = s_n; start_cyc = cyc;
                for (int i = 0; i < s_n; i++) s_arr[i] = mem[i];
                for (int i = 0; i < s_n; i++)
                    for (int j = 0; j + 1 < s_n - i; j++)
                        if (s_arr[j] > s_arr[j+1]) begin
                            s_tmp = s_arr[j]; s_arr[j] = s_arr[j+1]; s_arr[j+1] = s_tmp;
                        end
                srt_done = stale;
                for (int i = 0; i < s_n; i += 2) begin
                    @(negedge clk);
                    if (s_epoch != epoch) break;
                    srt_done      = stale && (i == 0);
                    srt_address_a = AW'(i);
                    srt_data_a    = s_arr[i];
                    srt_wren_a    = 1'b1;
                    srt_address_b = AW'(i + 1);
                    srt_data_b    = s_arr[(i + 1) % DEPTH];
                    srt_wren_b    = (i + 1 < s_n);
                end
                @(negedge clk);
                srt_done = 1'b0; srt_wren_a = 1'b0; srt_wren_b = 1'b0;
                srt_address_a = '0; srt_address_b = '0;
                s_d = long_sort ? 30 : (stale ? 20 : int'($urandom_range(1, 4)));
                for (int k = 0; k < s_d && s_epoch == epoch; k++) @(negedge clk);
                if (s_epoch == epoch && rst_n) begin
                    srt_done = 1'b1; done_cyc = cyc;
                    @(negedge clk);
                    srt_done = 1'b0;
                end
                busy = 0;
            end
        end
    end

    // Monitor: pops the expected queue on every accepted output beat.
    logic [W-1:0] held, cur, got;
    bit           held_v = 0, sorted_flag;
    always @(negedge clk) begin
        if (!rst_n) held_v = 0;
        else begin
            cur = {src_sop, src_eop, src_data};
            if (held_v) check("stall_hold", {src_valid, cur}, {1'b1, held});
            if (src_valid) begin
                if (!src_ready) begin
                    held = cur; held_v = 1;
                end else begin
                    held_v = 0;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_word: got %0h expected none at %0t", cur, $time);
                    end else begin
                        got = exp_q.pop_front();
                        check("out_word", cur, got);
                        check("out_while_sorting", 64'(busy), 0);
                        if (got[W-2]) begin
                            if (exp_ovf_q.size() > 0) check("overflow", overflow, exp_ovf_q.pop_front());
`ifdef SORT_STATS_EN
                            if (exp_sorted_q.size() > 0) begin
                                sorted_flag = exp_sorted_q.pop_front();
                                check("sort_cycles", sort_cycles, sorted_flag ? 64'(done_cyc - start_cyc + 1) : 0);
                            end
`endif
                        end
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
        int guard = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        snk_data = d; snk_valid = 1'b1; snk_sop = s; snk_eop = e;
        while (!snk_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) check("sink_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    endtask

    // Reference: first DEPTH words are kept, sorted ascending when there are two or more.
    task automatic send_packet();
        logic [DW-1:0] st[$];
        logic [DW-1:0] t;
        int n;
        n = (pkt.size() > DEPTH) ? DEPTH : pkt.size();
        for (int i = 0; i < n; i++) st.push_back(pkt[i]);
        for (int i = 0; i < n; i++)
            for (int j = 0; j + 1 < n - i; j++)
                if (st[j] > st[j+1]) begin
                    t = st[j]; st[j] = st[j+1]; st[j+1] = t;
                end
        for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), (i == n - 1), st[i]});
        exp_ovf_q.push_back(pkt.size() > DEPTH);
        exp_sorted_q.push_back(n > 1);
        for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], (i == 0), (i == pkt.size() - 1));
    endtask

    task automatic random_packet(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(DW'($urandom_range(0, (1 << DW) - 1)));
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        check(name, {snk_ready, src_valid, src_sop, src_eop, src_data, srt_sorting, srt_max_counter,
                     overflow, ram_wren_a, ram_wren_b, ram_address_a, ram_address_b}, 0);
    endtask

    int s0;
    initial begin : main
        snk_data = '0; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", snk_ready, 1);

        send_beat(10'h55, 1'b0, 1'b0);
        s0 = starts;
        pkt = '{10'd5, 10'd3, 10'd9, 10'd1};
        send_packet();
        wait_drain("drain_4w");
        check("start_pulses_4w", starts - s0, 1);
        check("max_counter_4w", last_n, 4);

        s0 = starts;
        pkt = '{10'd7};
        send_packet();
        @(negedge clk); check("single_lat_c1", src_valid, 0);
        @(negedge clk); check("single_lat_c2", src_valid, 0);
        @(negedge clk); check("single_lat_c3", src_valid, 1);
        wait_drain("drain_1w");
        check("start_pulses_1w", starts - s0, 0);

        random_packet(10); send_packet(); wait_drain("drain_overflow");
        check("max_counter_overflow", last_n, DEPTH);
        random_packet(3); send_packet(); wait_drain("drain_after_overflow");

        ready_mode = 2;
        random_packet(8); send_packet(); wait_drain("drain_stall");
        ready_mode = 0;

        s0 = starts; stale = 1;
        random_packet(8); send_packet(); wait_drain("drain_stale_done");
        stale = 0;
        check("start_pulses_stale", starts - s0, 1);

        ready_mode = 1;
        for (int p = 0; p < 8; p++) begin
            random_packet($urandom_range(1, 10));
            send_packet();
        end
        wait_drain("drain_random");
        ready_mode = 0;

        long_sort = 1;
        random_packet(8); send_packet();
        repeat (5) @(negedge clk);
        #1;
        check("busy_before_reset", 64'(busy), 1);
        rst_n = 1'b0; epoch++;
        #1;
        check_reset("reset_mid_wait");
        exp_q.delete(); exp_ovf_q.delete(); exp_sorted_q.delete();
        repeat (3) @(negedge clk);
        long_sort = 0;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_mid_reset", snk_ready, 1);
        pkt = '{10'd700, 10'd12};
        send_packet();
        wait_drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
